// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator: pixel/line counters, sync/blank decode,
// line/frame strobes and an 8-bit frame counter, all registered and mutually aligned.
module vga_timing_gen #(
    parameter int H_DISPLAY       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_DISPLAY       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_DISP_END = 11'(H_DISPLAY);
    localparam logic [10:0] V_DISP_END = 11'(V_DISPLAY);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic        SYNC_ON    = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    // Counters are 10 bits wide; larger rasters cannot be represented.
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [9:0]  hpos_q, hpos_d;
    logic [9:0]  vpos_q, vpos_d;
    logic [7:0]  frame_q, frame_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        display_on_q, display_on_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [10:0] h_ext_s;
    logic [10:0] v_ext_s;

    // Next raster position and the decode of that position, so outputs line up with hpos/vpos.
    always_comb begin
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        frame_d = frame_q;
        if (ena) begin
            if (hpos_q == H_LAST) begin
                hpos_d = 10'd0;
                if (vpos_q == V_LAST) begin
                    vpos_d  = 10'd0;
                    frame_d = frame_q + 8'd1;
                end else begin
                    vpos_d = vpos_q + 10'd1;
                end
            end else begin
                hpos_d = hpos_q + 10'd1;
            end
        end else begin
            hpos_d = hpos_q;
        end

        h_ext_s = {1'b0, hpos_d};
        v_ext_s = {1'b0, vpos_d};

        if ((h_ext_s >= H_SYNC_BEG) && (h_ext_s < H_SYNC_END)) begin
            hsync_d = SYNC_ON;
        end else begin
            hsync_d = ~SYNC_ON;
        end

        if ((v_ext_s >= V_SYNC_BEG) && (v_ext_s < V_SYNC_END)) begin
            vsync_d = SYNC_ON;
        end else begin
            vsync_d = ~SYNC_ON;
        end

        display_on_d = (h_ext_s < H_DISP_END) && (v_ext_s < V_DISP_END);
        // Strobes only fire on an advancing clock so a frozen raster never repeats them.
        line_start_d  = ena && (hpos_d == 10'd0);
        frame_start_d = ena && (hpos_d == 10'd0) && (vpos_d == 10'd0);
    end

    // State and output registers; reset parks one pixel before (0, 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpos_q        <= H_LAST;
            vpos_q        <= V_LAST;
            frame_q       <= 8'hFF;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_q       <= frame_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame       = frame_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: standard timing, positive-polarity variant and a
// shrunken raster used for whole-frame and frame-counter wrap checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    logic rst_m = 1'b1, ena_m = 1'b0;
    logic rst_p = 1'b1, rst_w = 1'b1, ena_x = 1'b1;

    logic       hs_m, vs_m, de_m, ls_m, fs_m;
    logic [9:0] hp_m, vp_m;
    logic [7:0] fr_m;
    logic       hs_p, vs_p, de_p, ls_p, fs_p;
    logic [9:0] hp_p, vp_p;
    logic [7:0] fr_p;
    logic       hs_w, vs_w, de_w, ls_w, fs_w;
    logic [9:0] hp_w, vp_w;
    logic [7:0] fr_w;

    vga_timing_gen dut (
        .clk(clk), .rst(rst_m), .ena(ena_m), .hsync(hs_m), .vsync(vs_m),
        .display_on(de_m), .hpos(hp_m), .vpos(vp_m), .line_start(ls_m),
        .frame_start(fs_m), .frame(fr_m)
    );

    vga_timing_gen #(.SYNC_ACTIVE_LOW(0)) dut_p (
        .clk(clk), .rst(rst_p), .ena(ena_x), .hsync(hs_p), .vsync(vs_p),
        .display_on(de_p), .hpos(hp_p), .vpos(vp_p), .line_start(ls_p),
        .frame_start(fs_p), .frame(fr_p)
    );

    // 10 x 7 raster: hsync at hpos 6..8, vsync at vpos 4..5, 4x3 visible.
    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE_LOW(0)
    ) dut_w (
        .clk(clk), .rst(rst_w), .ena(ena_x), .hsync(hs_w), .vsync(vs_w),
        .display_on(de_w), .hpos(hp_w), .vpos(vp_w), .line_start(ls_w),
        .frame_start(fs_w), .frame(fr_w)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_m();
        check_val("rst_hpos", 32'(hp_m), 32'd799);
        check_val("rst_vpos", 32'(vp_m), 32'd524);
        check_val("rst_frame", 32'(fr_m), 32'hFF);
        check_val("rst_hsync", 32'(hs_m), 32'd1);
        check_val("rst_vsync", 32'(vs_m), 32'd1);
        check_val("rst_de", 32'(de_m), 32'd0);
        check_val("rst_ls", 32'(ls_m), 32'd0);
        check_val("rst_fs", 32'(fs_m), 32'd0);
    endtask

    initial begin
        int waited;
        int vs_cnt, de_cnt, fs_cnt;
        logic [7:0] exp_frame;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_reset_m();
        rst_m = 1'b0;
        ena_m = 1'b1;
        @(negedge clk);
        check_val("first_hpos", 32'(hp_m), 32'd0);
        check_val("first_vpos", 32'(vp_m), 32'd0);
        check_val("first_frame", 32'(fr_m), 32'h00);
        check_val("first_fs", 32'(fs_m), 32'd1);
        check_val("first_ls", 32'(ls_m), 32'd1);
        check_val("first_de", 32'(de_m), 32'd1);
        check_val("first_vsync", 32'(vs_m), 32'd1);

        // ---------------- line 0 ----------------
        for (int i = 0; i < 800; i++) begin
            check_val("line_hpos", 32'(hp_m), 32'(i));
            check_val("line_de", 32'(de_m), (i < 640) ? 32'd1 : 32'd0);
            check_val("line_hsync", 32'(hs_m), (i >= 656 && i < 752) ? 32'd0 : 32'd1);
            check_val("line_ls", 32'(ls_m), (i == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check_val("wrap_hpos", 32'(hp_m), 32'd0);
        check_val("wrap_vpos", 32'(vp_m), 32'd1);
        check_val("wrap_ls", 32'(ls_m), 32'd1);
        check_val("wrap_fs", 32'(fs_m), 32'd0);

        // ---------------- freeze at (799, 10) ----------------
        waited = 0;
        while (!(hp_m == 10'd799 && vp_m == 10'd10) && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        check_val("reach_799_10", (waited < 20000) ? 32'd1 : 32'd0, 32'd1);
        ena_m = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("frz_hpos", 32'(hp_m), 32'd799);
            check_val("frz_vpos", 32'(vp_m), 32'd10);
            check_val("frz_ls", 32'(ls_m), 32'd0);
            check_val("frz_hsync", 32'(hs_m), 32'd1);
            check_val("frz_vsync", 32'(vs_m), 32'd1);
            check_val("frz_de", 32'(de_m), 32'd0);
        end
        ena_m = 1'b1;
        @(negedge clk);
        check_val("ren_hpos", 32'(hp_m), 32'd0);
        check_val("ren_vpos", 32'(vp_m), 32'd11);
        check_val("ren_ls", 32'(ls_m), 32'd1);
        // Freeze while the strobe is high: it must drop and not repeat.
        ena_m = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_val("frz0_hpos", 32'(hp_m), 32'd0);
            check_val("frz0_ls", 32'(ls_m), 32'd0);
            check_val("frz0_de", 32'(de_m), 32'd1);
        end
        ena_m = 1'b1;
        @(negedge clk);
        check_val("ren2_hpos", 32'(hp_m), 32'd1);
        check_val("ren2_ls", 32'(ls_m), 32'd0);

        // ---------------- mid-frame asynchronous reset ----------------
        waited = 0;
        while (!(hp_m == 10'd300 && vp_m == 10'd12) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check_val("reach_300_12", (waited < 2000) ? 32'd1 : 32'd0, 32'd1);
        #2 rst_m = 1'b1;
        #1;
        check_reset_m();
        @(negedge clk);
        rst_m = 1'b0;
        @(negedge clk);
        check_val("mrst_hpos", 32'(hp_m), 32'd0);
        check_val("mrst_vpos", 32'(vp_m), 32'd0);
        check_val("mrst_frame", 32'(fr_m), 32'h00);
        check_val("mrst_fs", 32'(fs_m), 32'd1);

        // ---------------- positive sync polarity ----------------
        check_val("pol_rst_hsync", 32'(hs_p), 32'd0);
        check_val("pol_rst_vsync", 32'(vs_p), 32'd0);
        rst_p = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 800; i++) begin
            check_val("pol_hpos", 32'(hp_p), 32'(i));
            check_val("pol_hsync", 32'(hs_p), (i >= 656 && i < 752) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // ---------------- small raster: whole frames and frame wrap ----------------
        check_val("w_rst_hpos", 32'(hp_w), 32'd9);
        check_val("w_rst_vpos", 32'(vp_w), 32'd6);
        check_val("w_rst_frame", 32'(fr_w), 32'hFF);
        rst_w = 1'b0;
        @(negedge clk);
        exp_frame = 8'h00;
        vs_cnt = 0;
        de_cnt = 0;
        fs_cnt = 0;
        for (int c = 0; c < 257 * 70; c++) begin
            check_val("w_hpos", 32'(hp_w), 32'(c % 10));
            check_val("w_vpos", 32'(vp_w), 32'((c / 10) % 7));
            check_val("w_fs", 32'(fs_w), (c % 70 == 0) ? 32'd1 : 32'd0);
            check_val("w_ls", 32'(ls_w), (c % 10 == 0) ? 32'd1 : 32'd0);
            check_val("w_vsync", 32'(vs_w),
                      (((c / 10) % 7) >= 4 && ((c / 10) % 7) < 6) ? 32'd1 : 32'd0);
            if (c % 70 == 0) begin
                check_val("w_frame", 32'(fr_w), 32'(exp_frame));
                exp_frame = exp_frame + 8'd1;
            end
            if (c < 70) begin
                vs_cnt += int'(vs_w);
                de_cnt += int'(de_w);
                fs_cnt += int'(fs_w);
            end
            if (c == 69) begin
                check_val("w_vs_count", 32'(vs_cnt), 32'd20);
                check_val("w_de_count", 32'(de_cnt), 32'd12);
                check_val("w_fs_count", 32'(fs_cnt), 32'd1);
                check_val("w_last_hpos", 32'(hp_w), 32'd9);
                check_val("w_last_vpos", 32'(vp_w), 32'd6);
            end
            @(negedge clk);
        end
        check_val("w_final_frame", 32'(fr_w), 32'h01);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing from the 25.175 MHz pixel clock. Counts pixel/line position and produces hsync, vsync and display_on, plus line/frame strobes and a frame counter.
- Sits directly upstream of the demoscene pixel/PRNG mixing stage. Its hsync/vsync feed the TinyVGA PMOD sync bits; hpos/vpos/frame drive pattern and animation logic.
- All outputs are registered and mutually aligned: every output in a given cycle describes the same (hpos, vpos).

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 (VGA 640x480 standard); 0 = sync pulses drive 1

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous reset, active-high
- ena  input  1  advance enable; low freezes the raster
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- display_on  output  1  high when hpos < H_DISPLAY and vpos < V_DISPLAY
- hpos  output  10  current pixel column, 0..H_TOTAL-1
- vpos  output  10  current line, 0..V_TOTAL-1
- line_start  output  1  one-cycle strobe when hpos becomes 0
- frame_start  output  1  one-cycle strobe when (hpos, vpos) becomes (0, 0)
- frame  output  8  frame counter for animation

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- H_TOTAL and V_TOTAL must each be at most 1024. Elaboration fails otherwise.
- Reset (async assert, sync release to clk):
  - hpos = H_TOTAL-1, vpos = V_TOTAL-1, frame = 8'hFF
  - display_on = 0, line_start = 0, frame_start = 0
  - hsync = vsync = inactive level (1 when SYNC_ACTIVE_LOW = 1)
  - Result: the first enabled clock after release lands on (0, 0) with frame_start = 1 and frame = 0.
- Reset asserted mid-line or mid-frame forces the reset state immediately, without waiting for a clock edge.
- Each clock with ena = 1:
  - If hpos = H_TOTAL-1: hpos -> 0. Otherwise hpos -> hpos+1.
  - On an hpos wrap: vpos -> 0 if vpos = V_TOTAL-1, else vpos+1.
  - On a wrap to (0, 0): frame -> frame+1, modulo 256 (8'hFF -> 8'h00).
- Output decode is computed from the next position and registered, so it is aligned with hpos/vpos (zero latency relative to position):
  - hsync active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC, i.e. hpos 656..751.
  - vsync active iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC, i.e. vpos 490..491.
  - vsync depends only on vpos; it changes exactly at hpos = 0.
  - line_start = 1 iff the new hpos = 0.
  - frame_start = 1 iff the new position = (0, 0). frame_start implies line_start in the same cycle.
- ena = 0: hpos, vpos, frame, hsync, vsync and display_on hold their values. line_start and frame_start are forced to 0, so a strobe never repeats while frozen.
- Frame period: H_TOTAL x V_TOTAL = 420000 enabled clocks. line_start period: 800 enabled clocks.
- No combinational path from any input to any output except the async reset.

Test Plan:
- Reset: assert rst asynchronously, then release. Required: hpos = 799, vpos = 524, frame = FF, hsync = vsync = 1, display_on = 0, strobes = 0. First enabled clock gives hpos = 0, vpos = 0, frame = 00, frame_start = 1, line_start = 1, display_on = 1.
- Horizontal line: step through line 0. Required: display_on = 1 for hpos 0..639 and 0 for 640..799; hsync = 0 exactly for hpos 656..751. After hpos 799: hpos = 0, vpos = 1, line_start = 1, frame_start = 0.
- Full frame: run 420000 enabled clocks. Required: vsync = 0 exactly during vpos 490..491 (1600 clocks); display_on high for exactly 307200 clocks; frame_start once; frame increments 00 -> 01; vpos 524 -> 0 on the hpos 799 -> 0 wrap.
- ena freeze: deassert ena at hpos = 799, vpos = 10 for 5 clocks. Required: all position and sync outputs held, line_start = 0 throughout. On re-enable: hpos = 0, vpos = 11, line_start = 1 once.
- Mid-frame reset: assert rst at hpos = 300, vpos = 200 between clock edges. Required: outputs reach the reset values before the next edge. After release, timing restarts at (0, 0) with frame = 00.
- Polarity and wrap: with SYNC_ACTIVE_LOW = 0, hsync = 1 only for hpos 656..751. Run 256 frames. Required: frame wraps FF -> 00 with no glitch on frame_start.
